// File: rtl/pkt_read_arbiter.sv
// Round-robin read arbiter for four output ports sharing one single-port packet RAM.
// Grants one request per cycle and returns each word to its requester after a fixed latency.
module pkt_read_arbiter #(
  parameter int RAM_LAT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [15:0]  iv_pkt_raddr_p0,
  input  logic [15:0]  iv_pkt_raddr_p1,
  input  logic [15:0]  iv_pkt_raddr_p2,
  input  logic [15:0]  iv_pkt_raddr_p3,
  input  logic         i_pkt_rd_p0,
  input  logic         i_pkt_rd_p1,
  input  logic         i_pkt_rd_p2,
  input  logic         i_pkt_rd_p3,
  output logic         o_pkt_raddr_ack_p0,
  output logic         o_pkt_raddr_ack_p1,
  output logic         o_pkt_raddr_ack_p2,
  output logic         o_pkt_raddr_ack_p3,
  output logic [15:0]  ov_ram_raddr,
  output logic         o_ram_rd,
  input  logic [133:0] iv_ram_rdata,
  output logic [133:0] ov_pkt_data_p0,
  output logic [133:0] ov_pkt_data_p1,
  output logic [133:0] ov_pkt_data_p2,
  output logic [133:0] ov_pkt_data_p3,
  output logic         o_pkt_data_wr_p0,
  output logic         o_pkt_data_wr_p1,
  output logic         o_pkt_data_wr_p2,
  output logic         o_pkt_data_wr_p3
);

  logic [3:0]         rd_req;
  logic [3:0]         elig;
  logic [15:0]        raddr [4];
  logic [3:0]         ack_q;
  logic [3:0]         wr_q;
  logic [1:0]         ptr_q;
  logic [1:0]         rd_id_q;
  logic [1:0]         gnt_id;
  logic [1:0]         cand;
  logic               gnt_vld;
  logic [RAM_LAT-1:0] tag_v;
  logic [1:0]         tag_id [RAM_LAT];
  logic [133:0]       data_q;

  assign rd_req   = {i_pkt_rd_p3, i_pkt_rd_p2, i_pkt_rd_p1, i_pkt_rd_p0};
  assign raddr[0] = iv_pkt_raddr_p0;
  assign raddr[1] = iv_pkt_raddr_p1;
  assign raddr[2] = iv_pkt_raddr_p2;
  assign raddr[3] = iv_pkt_raddr_p3;

  // A port still holding rd during its ack cycle must not be granted twice for one address.
  assign elig = rd_req & ~ack_q;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ptr_q;
    cand    = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q        <= '0;
      o_ram_rd     <= 1'b0;
      ov_ram_raddr <= '0;
      ptr_q        <= '0;
      rd_id_q      <= '0;
      tag_v        <= '0;
      for (int k = 0; k < RAM_LAT; k++) tag_id[k] <= '0;
      wr_q         <= '0;
      data_q       <= '0;
    end else begin
      ack_q    <= gnt_vld ? (4'b0001 << gnt_id) : 4'b0000;
      o_ram_rd <= gnt_vld;
      if (gnt_vld) begin
        ov_ram_raddr <= raddr[gnt_id];
        ptr_q        <= gnt_id + 2'd1;
        rd_id_q      <= gnt_id;
      end

      // Tag rides alongside the RAM access so its tail lines up with valid read data.
      tag_v[0]  <= o_ram_rd;
      tag_id[0] <= rd_id_q;
      for (int k = 1; k < RAM_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end

      wr_q <= tag_v[RAM_LAT-1] ? (4'b0001 << tag_id[RAM_LAT-1]) : 4'b0000;
      if (tag_v[RAM_LAT-1]) data_q <= iv_ram_rdata;
    end
  end

  assign o_pkt_raddr_ack_p0 = ack_q[0];
  assign o_pkt_raddr_ack_p1 = ack_q[1];
  assign o_pkt_raddr_ack_p2 = ack_q[2];
  assign o_pkt_raddr_ack_p3 = ack_q[3];
  assign o_pkt_data_wr_p0   = wr_q[0];
  assign o_pkt_data_wr_p1   = wr_q[1];
  assign o_pkt_data_wr_p2   = wr_q[2];
  assign o_pkt_data_wr_p3   = wr_q[3];
  assign ov_pkt_data_p0     = data_q;
  assign ov_pkt_data_p1     = data_q;
  assign ov_pkt_data_p2     = data_q;
  assign ov_pkt_data_p3     = data_q;

endmodule
